// File: rtl/m72_pkg.sv
// Shared types and helpers for the V30 interrupt-acknowledge bridge.
package m72_pkg;

  localparam int VEC_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    INTA1,
    INTA1_GAP,
    INTA2,
    ACK,
    HOLDOFF
  } inta_state_t;

  // PIC vector address {base, level, 2'b00} -> CPU vector type byte
  function automatic logic [7:0] vec_to_type(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[8:2]};
  endfunction

endpackage

// File: rtl/m72_inta_ctrl.sv
// Bridges the PIC level request onto the V30 two-pulse INTA sequence,
// drives the vector type on the second INTA, and acks the PIC once.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no request in flight; latch vector when PIC requests
// REQ       | cpu_intr asserted, waiting for first INTA rise
// INTA1     | first INTA cycle in progress, waiting for its fall
// INTA1_GAP | between INTA cycles, waiting for second rise
// INTA2     | second INTA cycle, vector driven while cpu_inta=1
// ACK       | one-cycle acknowledge to the PIC
// HOLDOFF   | guard time; also waits for the PIC to drop its request
module m72_inta_ctrl
  import m72_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int INTA_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             pic_int_req,
  input  logic [VEC_W-1:0] pic_int_vector,
  output logic             pic_int_ack,
  output logic             cpu_intr,
  input  logic             cpu_inta,
  output logic [7:0]       cpu_vector,
  output logic             cpu_vector_oe,
  output logic [7:0]       ack_count,
  output logic [7:0]       abort_count
);

  localparam logic [9:0] TIMER_LAST = 10'(INTA_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLDOFF_CYCLES);

  inta_state_t      state, state_nxt;
  logic             inta_d;
  logic             inta_rise, inta_fall;
  logic [VEC_W-1:0] vec_q;
  logic [9:0]       timer;
  logic [7:0]       hold_cnt;
  logic             in_inta1_window;
  logic             timeout;
  logic             unused_vec_lsb;

  assign inta_rise       = cpu_inta & ~inta_d;
  assign inta_fall       = ~cpu_inta & inta_d;
  assign in_inta1_window = (state == INTA1) || (state == INTA1_GAP);
  assign timeout         = in_inta1_window && (timer == TIMER_LAST);
  assign unused_vec_lsb  = ^vec_q[1:0];

  // State register, advanced only on clock-enabled cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // Next-state decode; timeout wins over INTA edges in the first-INTA window
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pic_int_req) state_nxt = REQ;
      REQ: begin
        if (inta_rise)         state_nxt = INTA1;
        else if (!pic_int_req) state_nxt = IDLE;
      end
      INTA1: begin
        if (timeout)        state_nxt = IDLE;
        else if (inta_fall) state_nxt = INTA1_GAP;
      end
      INTA1_GAP: begin
        if (timeout)        state_nxt = IDLE;
        else if (inta_rise) state_nxt = INTA2;
      end
      INTA2:     if (inta_fall) state_nxt = ACK;
      ACK:       state_nxt = HOLDOFF;
      HOLDOFF:   if ((hold_cnt == 8'd0) && !pic_int_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Edge detector, vector latch, INTA window timer, holdoff counter, debug counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inta_d      <= 1'b0;
      vec_q       <= '0;
      timer       <= '0;
      hold_cnt    <= '0;
      ack_count   <= '0;
      abort_count <= '0;
    end else if (ce) begin
      inta_d <= cpu_inta;
      if ((state == IDLE) && pic_int_req) vec_q <= pic_int_vector;
      if (state == REQ)         timer <= '0;
      else if (in_inta1_window) timer <= timer + 10'd1;
      if (state == ACK) begin
        hold_cnt  <= HOLD_LOAD;
        ack_count <= ack_count + 8'd1;
      end else if ((state == HOLDOFF) && (hold_cnt != 8'd0)) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
      if (timeout && (abort_count != 8'hFF)) abort_count <= abort_count + 8'd1;
    end
  end

  // Outputs decoded from state; oe follows the live INTA strobe
  always_comb begin
    cpu_intr      = (state == REQ) || (state == INTA1);
    pic_int_ack   = (state == ACK);
    cpu_vector_oe = (state == INTA2) && cpu_inta;
    cpu_vector    = (state == INTA2) ? vec_to_type(vec_q) : 8'h00;
  end

endmodule

// File: tb/tb_m72_inta_ctrl.sv
// Randomized self-checking bench for m72_inta_ctrl.
module tb_m72_inta_ctrl;

  localparam int HOLD = 4;
  localparam int TOUT = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       pic_int_req;
  logic [8:0] pic_int_vector;
  logic       pic_int_ack;
  logic       cpu_intr;
  logic       cpu_inta;
  logic [7:0] cpu_vector;
  logic       cpu_vector_oe;
  logic [7:0] ack_count;
  logic [7:0] abort_count;

  int total = 0;
  int bad   = 0;
  int ce_div = 1;
  int exp_ack = 0;
  int exp_abort = 0;

  m72_inta_ctrl #(.HOLDOFF_CYCLES(HOLD), .INTA_TIMEOUT(TOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ce             (ce),
    .pic_int_req    (pic_int_req),
    .pic_int_vector (pic_int_vector),
    .pic_int_ack    (pic_int_ack),
    .cpu_intr       (cpu_intr),
    .cpu_inta       (cpu_inta),
    .cpu_vector     (cpu_vector),
    .cpu_vector_oe  (cpu_vector_oe),
    .ack_count      (ack_count),
    .abort_count    (abort_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One enabled clock followed by ce_div-1 gated clocks; outputs must hold while gated
  task automatic ce_cycle();
    int h_intr, h_ack;
    ce = 1'b1;
    @(posedge clk); #1;
    h_intr = int'(cpu_intr);
    h_ack  = int'(pic_int_ack);
    for (int k = 1; k < ce_div; k++) begin
      ce = 1'b0;
      @(posedge clk); #1;
      check_val("hold_intr", int'(cpu_intr), h_intr);
      check_val("hold_ack", int'(pic_int_ack), h_ack);
    end
  endtask

  // mode 0: full sequence, PIC drops req on ack, holdoff allowed to expire
  // mode 1: PIC drops req on ack, return right after the ack cycle
  // mode 2: PIC keeps req high after ack, return right after the ack cycle
  task automatic run_seq(input logic [8:0] vec, input int w1, input int gap,
                         input int w2, input int mode);
    int exp_type;
    exp_type = int'(vec) / 4;
    pic_int_vector = vec;
    pic_int_req = 1'b1;
    ce_cycle();
    check_val("intr_latency", int'(cpu_intr), 1);
    pic_int_vector = 9'($urandom);
    cpu_inta = 1'b1;
    if (mode == 0 && $urandom_range(0, 1) == 1) pic_int_req = 1'b0;
    for (int i = 0; i < w1; i++) begin
      ce_cycle();
      check_val("inta1_intr", int'(cpu_intr), 1);
      check_val("inta1_oe", int'(cpu_vector_oe), 0);
    end
    cpu_inta = 1'b0;
    for (int i = 0; i < gap; i++) begin
      ce_cycle();
      check_val("gap_intr", int'(cpu_intr), 0);
      check_val("gap_oe", int'(cpu_vector_oe), 0);
    end
    cpu_inta = 1'b1;
    #1;
    check_val("pre_inta2_oe", int'(cpu_vector_oe), 0);
    for (int i = 0; i < w2; i++) begin
      ce_cycle();
      check_val("inta2_oe", int'(cpu_vector_oe), 1);
      check_val("inta2_vec", int'(cpu_vector), exp_type);
      check_val("inta2_ack", int'(pic_int_ack), 0);
    end
    cpu_inta = 1'b0;
    #1;
    check_val("post_inta2_oe", int'(cpu_vector_oe), 0);
    ce_cycle();
    check_val("ack_pulse", int'(pic_int_ack), 1);
    check_val("ack_intr", int'(cpu_intr), 0);
    if (mode != 2) pic_int_req = 1'b0;
    ce_cycle();
    check_val("ack_single", int'(pic_int_ack), 0);
    exp_ack = (exp_ack + 1) % 256;
    check_val("ack_count", int'(ack_count), exp_ack);
    if (mode == 0) repeat (HOLD + 1) ce_cycle();
  endtask

  // First INTA only, then silence until the abort; req stays high throughout
  task automatic run_timeout();
    pic_int_vector = 9'($urandom);
    pic_int_req = 1'b1;
    ce_cycle();
    check_val("to_intr", int'(cpu_intr), 1);
    cpu_inta = 1'b1;
    ce_cycle();
    cpu_inta = 1'b0;
    for (int i = 1; i <= TOUT + 4; i++) begin
      ce_cycle();
      check_val("to_no_ack", int'(pic_int_ack), 0);
      if (i == TOUT - 1) check_val("to_early", int'(abort_count), exp_abort);
    end
    if (exp_abort < 255) exp_abort++;
    check_val("to_abort_count", int'(abort_count), exp_abort);
    check_val("to_reassert", int'(cpu_intr), 1);
    pic_int_req = 1'b0;
    ce_cycle();
    check_val("to_withdraw", int'(cpu_intr), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ce = 1'b0;
    pic_int_req = 1'b0;
    pic_int_vector = '0;
    cpu_inta = 1'b0;
    #1;
    check_val("rst_intr", int'(cpu_intr), 0);
    check_val("rst_ack", int'(pic_int_ack), 0);
    check_val("rst_oe", int'(cpu_vector_oe), 0);
    check_val("rst_vec", int'(cpu_vector), 0);
    check_val("rst_ackcnt", int'(ack_count), 0);
    check_val("rst_abcnt", int'(abort_count), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ce_cycle();

    // normal sequence with the reference vector
    run_seq(9'h124, 3, 2, 3, 0);
    check_val("normal_abort", int'(abort_count), 0);

    // withdraw before any INTA
    pic_int_vector = 9'h0A8;
    pic_int_req = 1'b1;
    ce_cycle();
    check_val("wd_intr1", int'(cpu_intr), 1);
    ce_cycle();
    check_val("wd_intr2", int'(cpu_intr), 1);
    pic_int_req = 1'b0;
    ce_cycle();
    check_val("wd_drop", int'(cpu_intr), 0);
    check_val("wd_ack", int'(pic_int_ack), 0);
    check_val("wd_abort", int'(abort_count), 0);
    repeat (2) ce_cycle();
    check_val("wd_idle", int'(cpu_intr), 0);

    // holdoff with req held, spurious INTA injected, then second sequence
    for (int d = 1; d <= 3; d += 2) begin
      ce_div = d;
      run_seq(9'($urandom), 2, 1, 2, 2);
      for (int i = 0; i < 10; i++) begin
        cpu_inta = (i == 3 || i == 4);
        ce_cycle();
        check_val("hold_no_intr", int'(cpu_intr), 0);
        check_val("spur_oe", int'(cpu_vector_oe), 0);
        check_val("spur_ack", int'(pic_int_ack), 0);
      end
      cpu_inta = 1'b0;
      pic_int_req = 1'b0;
      ce_cycle();
      check_val("hold_idle", int'(cpu_intr), 0);
      run_seq(9'($urandom), 1, 2, 1, 0);
    end
    ce_div = 1;

    // holdoff boundary: PIC re-raises req after k ce cycles low
    for (int k = 4; k <= 7; k++) begin
      run_seq(9'($urandom), 1, 1, 1, 1);
      repeat (k - 1) ce_cycle();
      pic_int_req = 1'b1;
      ce_cycle();
      check_val("holdoff_edge", int'(cpu_intr), (k >= HOLD + 2) ? 1 : 0);
      pic_int_req = 1'b0;
      repeat (HOLD + 2) ce_cycle();
      check_val("holdoff_clean", int'(cpu_intr), 0);
    end

    // timeout at full rate and with 1-in-3 ce
    run_timeout();
    ce_div = 3;
    run_timeout();
    run_seq(9'h1FC, 3, 2, 3, 0);
    ce_div = 1;

    // randomized sequences, enough to wrap ack_count
    for (int n = 0; n < 260; n++) begin
      ce_div = ($urandom_range(0, 3) == 0) ? 3 : 1;
      run_seq(9'($urandom), $urandom_range(1, 4), $urandom_range(1, 3),
              $urandom_range(1, 4), 0);
    end
    ce_div = 1;

    // abort counter saturation
    while (exp_abort < 255) run_timeout();
    run_timeout();

    // reset while the vector is on the bus
    pic_int_vector = 9'h155;
    pic_int_req = 1'b1;
    ce_cycle();
    cpu_inta = 1'b1;
    ce_cycle();
    cpu_inta = 1'b0;
    ce_cycle();
    cpu_inta = 1'b1;
    ce_cycle();
    check_val("mid_oe", int'(cpu_vector_oe), 1);
    reset_n = 1'b0;
    #1;
    check_val("arst_oe", int'(cpu_vector_oe), 0);
    check_val("arst_vec", int'(cpu_vector), 0);
    check_val("arst_intr", int'(cpu_intr), 0);
    check_val("arst_ack", int'(pic_int_ack), 0);
    check_val("arst_ackcnt", int'(ack_count), 0);
    check_val("arst_abcnt", int'(abort_count), 0);
    exp_ack = 0;
    exp_abort = 0;
    cpu_inta = 1'b0;
    ce_cycle();
    reset_n = 1'b1;
    run_seq(9'h155, 2, 2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
